// File: rtl/dac_slew_ctrl.sv
// Slew-rate limited DAC code controller: an asynchronous strobe captures a clamped
// target code, and dac ramps toward it in STEP-sized moves spaced DWELL+1 cycles apart.
module dac_slew_ctrl #(
    parameter int N     = 10,
    parameter int STEP  = 4,
    parameter int DWELL = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe,
    input  logic [N-1:0] value,
    input  logic [N-1:0] min_code,
    input  logic [N-1:0] max_code,
    input  logic         hold,
    output logic [N-1:0] dac,
    output logic         busy,
    output logic         settled,
    output logic         sat
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT} state_t;

    localparam logic [N:0]   STEP_W   = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N   = N'(STEP);
    localparam logic [7:0]   DWELL_M1 = 8'(DWELL - 1);

    state_t       state, state_n;
    logic [N-1:0] target, dac_n, clamp;
    logic [7:0]   cnt, cnt_n;
    logic [2:0]   sync_q;
    logic         cap, clamp_sat, settled_n, up;
    logic [N:0]   diff;

    // sync_q[1:0] is the 2-flop synchronizer; sync_q[2] is the edge detector's history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], strobe};
    end

    assign cap = sync_q[1] & ~sync_q[2];

    always_comb begin
        clamp     = value;
        clamp_sat = 1'b0;
        if (min_code > max_code) begin
            clamp     = min_code;
            clamp_sat = 1'b1;
        end else if (value < min_code) begin
            clamp     = min_code;
            clamp_sat = 1'b1;
        end else if (value > max_code) begin
            clamp     = max_code;
            clamp_sat = 1'b1;
        end
    end

    // Captures are independent of hold and of the ramp state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target <= '0;
            sat    <= 1'b0;
        end else if (cap) begin
            target <= clamp;
            sat    <= clamp_sat;
        end
    end

    assign up   = target > dac;
    assign diff = up ? ({1'b0, target} - {1'b0, dac}) : ({1'b0, dac} - {1'b0, target});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            dac     <= '0;
            cnt     <= '0;
            settled <= 1'b0;
        end else begin
            state   <= state_n;
            dac     <= dac_n;
            cnt     <= cnt_n;
            settled <= settled_n;
        end
    end

    // A full STEP move never overshoots, so dac stays inside [0, 2^N-1]
    always_comb begin
        state_n   = state;
        dac_n     = dac;
        cnt_n     = cnt;
        settled_n = 1'b0;
        if (!hold) begin
            case (state)
                S_IDLE: if (dac != target) state_n = S_STEP;
                S_STEP: begin
                    if (diff <= STEP_W) begin
                        dac_n     = target;
                        settled_n = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        dac_n   = up ? (dac + STEP_N) : (dac - STEP_N);
                        cnt_n   = DWELL_M1;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 8'd0) state_n = S_STEP;
                    else             cnt_n   = cnt - 8'd1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy = (dac != target);

endmodule

// File: tb/tb_dac_slew_ctrl.sv
// Scoreboard bench for dac_slew_ctrl: expected dac steps and their spacing are queued
// when a strobe is driven and checked as the DUT's dac changes.
module tb_dac_slew_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         reset, strobe, hold, busy, settled, sat;
    logic [N-1:0] value, min_code, max_code, dac;

    typedef struct {int val; int gap;} exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0;
    int settled_cnt = 0, settled_exp = 0;

    dac_slew_ctrl #(.N(N), .STEP(4), .DWELL(8)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .value(value),
        .min_code(min_code), .max_code(max_code), .hold(hold),
        .dac(dac), .busy(busy), .settled(settled), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_ramp(input int from, input int to, input int g0);
        int d = from;
        bit first = 1'b1;
        while (d != to) begin
            if (((to > d) ? to - d : d - to) <= 4) d = to;
            else d = (to > d) ? d + 4 : d - 4;
            exp_q.push_back('{val: d, gap: first ? g0 : 9});
            first = 1'b0;
        end
    endtask

    task automatic pulse(input int v);
        value  = N'(v);
        strobe = 1'b1;
        nclk(4);
        strobe = 1'b0;
        nclk(2);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            nclk(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        nclk(3);
        exp_q.delete();
        reset = 1'b1;
        nclk(1);
    endtask

    // Monitor: every dac change must match the queue head, with the expected spacing
    initial begin
        int   prev = 0, gap = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = int'(dac);
                gap  = 0;
            end else begin
                gap++;
                if (int'(dac) != prev) begin
                    if (exp_q.size() == 0) chk("unexpected_step", int'(dac), prev);
                    else begin
                        e = exp_q.pop_front();
                        chk("dac_step", int'(dac), e.val);
                        if (e.gap != 0) chk("step_gap", gap, e.gap);
                    end
                    gap  = 0;
                    prev = int'(dac);
                end
                if (settled) begin
                    settled_cnt++;
                    chk("settled_busy", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int total, n, s0;
        reset = 1'b0; strobe = 1'b0; hold = 1'b0; value = '0;
        min_code = '0; max_code = 10'd1023;
        nclk(3);
        chk("rst_dac", int'(dac), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_sat", int'(sat), 0);
        reset = 1'b1;
        nclk(2);

        // Basic ramp to 20 with capture latency check
        push_ramp(0, 20, 0);
        value = 10'd20; strobe = 1'b1;
        nclk(2);
        chk("cap_lat_edge2", int'(busy), 0);
        nclk(1);
        chk("cap_lat_edge3", int'(busy), 1);
        nclk(2); strobe = 1'b0; nclk(2);
        wait_drain(200);
        settled_exp++;
        chk("ramp20_settled", settled_cnt, settled_exp);
        chk("ramp20_busy", int'(busy), 0);
        chk("ramp20_dac", int'(dac), 20);

        // Clamping
        min_code = 10'd100; max_code = 10'd200;
        push_ramp(20, 200, 0);
        pulse(300);
        chk("clamp_hi_sat", int'(sat), 1);
        wait_drain(600);
        settled_exp++;
        push_ramp(200, 150, 0);
        pulse(150);
        chk("in_range_sat", int'(sat), 0);
        wait_drain(300);
        settled_exp++;
        chk("in_range_dac", int'(dac), 150);
        min_code = 10'd300; max_code = 10'd100;
        push_ramp(150, 300, 0);
        pulse(50);
        chk("min_gt_max_sat", int'(sat), 1);
        wait_drain(500);
        settled_exp++;
        chk("min_gt_max_dac", int'(dac), 300);
        min_code = '0; max_code = 10'd1023;

        // Reversal mid-ramp without a jump or counter restart
        do_reset();
        for (int v = 4; v <= 40; v += 4) exp_q.push_back('{val: v, gap: (v == 4) ? 0 : 9});
        pulse(80);
        wait_drain(200);
        push_ramp(40, 10, 9);
        pulse(10);
        wait_drain(200);
        settled_exp++;
        chk("reverse_dac", int'(dac), 10);

        // Hold freezes mid-WAIT and resumes with the remaining count
        push_ramp(10, 60, 0);
        total = exp_q.size();
        exp_q[2].gap = 59;
        pulse(60);
        n = 0;
        while (exp_q.size() > total - 2 && n < 100) begin nclk(1); n++; end
        chk("hold_reach18", int'(dac), 18);
        nclk(3);
        hold = 1'b1;
        s0 = settled_cnt;
        nclk(50);
        chk("hold_dac", int'(dac), 18);
        chk("hold_settled", settled_cnt, s0);
        hold = 1'b0;
        wait_drain(300);
        settled_exp++;
        chk("hold_final", int'(dac), 60);

        // Code-range boundaries
        do_reset();
        push_ramp(0, 1020, 0);
        pulse(1020);
        wait_drain(3000);
        push_ramp(1020, 1023, 0);
        pulse(1023);
        wait_drain(50);
        chk("top_dac", int'(dac), 1023);
        chk("top_sat", int'(sat), 0);
        push_ramp(1023, 2, 0);
        pulse(2);
        wait_drain(3000);
        push_ramp(2, 0, 0);
        pulse(0);
        wait_drain(50);
        chk("bottom_dac", int'(dac), 0);
        settled_exp += 4;
        chk("boundary_settled", settled_cnt, settled_exp);

        // Asynchronous reset mid-ramp
        max_code = 10'd50;
        push_ramp(0, 50, 0);
        pulse(100);
        nclk(24);
        #2 reset = 1'b0;
        #1;
        chk("arst_dac", int'(dac), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_settled", int'(settled), 0);
        chk("arst_sat", int'(sat), 0);
        nclk(3);
        exp_q.delete();
        max_code = 10'd1023;
        value = 10'd8; strobe = 1'b1;
        push_ramp(0, 8, 0);
        nclk(1);
        reset = 1'b1;
        wait_drain(100);
        settled_exp++;
        chk("rel_cap_dac", int'(dac), 8);

        // Strobe held high captures once; a capture equal to dac in IDLE is silent
        value = 10'd500;
        nclk(40);
        chk("held_dac", int'(dac), 8);
        chk("held_busy", int'(busy), 0);
        strobe = 1'b0; value = 10'd8;
        nclk(2);
        strobe = 1'b1;
        nclk(6);
        chk("eq_idle_busy", int'(busy), 0);
        chk("eq_idle_settled", settled_cnt, settled_exp);
        strobe = 1'b0;
        nclk(2);

        // Capture equal to dac during WAIT settles on the next STEP
        exp_q.push_back('{val: 12, gap: 0});
        pulse(60);
        wait_drain(50);
        pulse(12);
        chk("eq_wait_busy", int'(busy), 0);
        nclk(12);
        settled_exp++;
        chk("eq_wait_settled", settled_cnt, settled_exp);
        chk("eq_wait_dac", int'(dac), 12);
        chk("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_slew_ctrl.md
DAC_SLEW_CTRL -- requirements
Module: dac_slew_ctrl

Interface
REQ-001 Parameter: N, default 10, width of value, limits and DAC code.
REQ-002 Parameter: STEP, default 4, maximum DAC code change per step, 1..2^N-1.
REQ-003 Parameter: DWELL, default 8, clk cycles between steps, 1..255.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 strobe  input  1  new-code strobe, asynchronous to clk; a rising edge marks value as valid.
REQ-007 value  input  N  requested DAC code; held stable from before strobe rises until at least 4 clk cycles after.
REQ-008 min_code  input  N  lower code limit, quasi-static.
REQ-009 max_code  input  N  upper code limit, quasi-static.
REQ-010 hold  input  1  freeze; while high, dac and the dwell counter do not change.
REQ-011 dac  output  N  registered DAC control code.
REQ-012 busy  output  1  high while dac != target.
REQ-013 settled  output  1  single-cycle pulse when dac reaches target after a ramp.
REQ-014 sat  output  1  high when the last captured value was clamped.

Function
REQ-015 strobe shall pass through a 2-flop synchronizer followed by a rising-edge detector; capture occurs on the 3rd rising clk edge after strobe is sampled high.
REQ-016 Capture: target <= value clamped to [min_code, max_code]; sat <= 1 if clamped, else 0.
REQ-017 If min_code > max_code: target <= min_code and sat <= 1.
REQ-018 Differences and comparisons shall be computed in N+1 bits; dac shall never wrap below 0 or above 2^N-1.
REQ-019 FSM states: IDLE, STEP, WAIT.
REQ-020 IDLE: if dac != target, go to STEP on the next edge; otherwise remain.
REQ-021 STEP: if |target-dac| <= STEP, set dac <= target, pulse settled, and go to IDLE.
REQ-022 Otherwise, STEP moves dac by STEP toward target, loads the dwell counter with DWELL-1, and goes to WAIT.
REQ-023 WAIT: decrement the counter; at 0, go to STEP; DWELL=1 gives one step every 2 cycles.
REQ-024 A capture during STEP or WAIT shall replace target without restarting the counter; ramping continues from the current dac, in the new direction if required.
REQ-025 If a capture sets target equal to the current dac during WAIT, the next STEP shall pulse settled and return to IDLE.
REQ-026 A capture equal to dac in IDLE shall produce no settled pulse and no state change.
REQ-027 Capture and step on the same edge: the step uses the old target; the new target applies from the next cycle.
REQ-028 hold high shall freeze state, dac and the counter, and suppress settled; captures still update target and sat.
REQ-029 busy shall be combinational from registered state: (dac != target).
REQ-030 A strobe held high shall produce exactly one capture; a new capture requires strobe low for at least 2 clk cycles.

Reset
REQ-031 While reset is low: dac=0, target=0, state=IDLE, counter=0, sat=0, settled=0, busy=0, synchronizer flops=0.
REQ-032 Reset asserted mid-ramp shall abort immediately, with no further dac change.
REQ-033 After reset release, the first strobe edge shall capture normally; a strobe high at release counts as a rising edge.

Verification
REQ-034 Reset, value=20, strobe rising, defaults: dac steps 0,4,8,12,16 spaced 9 cycles; final step 20 with settled pulse; busy falls.
REQ-035 min=100, max=200, value=300: target=200, sat=1; value=150 next: sat=0.
REQ-036 Mid-ramp at dac=40 toward 80, new value=10: dac steps 36,32,... down to 10 with no jump.
REQ-037 hold=1 for 50 cycles mid-WAIT: dac and counter constant, settled never pulses; ramp resumes with the remaining count after release.
REQ-038 Boundaries: N=10, value=1023 from dac=1020 with STEP=4 settles at 1023 with no wrap; value=0 from dac=2 settles at 0.
REQ-039 Reset low at cycle 30 of a ramp: all outputs at their reset values within the same cycle, asynchronously.
